apb_reg_top: RTL and testbench
==============================

# apb_reg_top

APB3 slave register block: five read/write control registers driven out to the design and three read-only status inputs sampled from it, all reachable over one APB port. It sits between the system APB master (the team's APB driver) and the peripheral logic it configures and observes. It supports zero or more wait states, and signals address and access errors on PSLVERR.

## Interface
- AWIDTH, 4: APB address width (word-indexed register address).
- DWIDTH, 8: data width of PWDATA, PRDATA and every register.
- WAIT_CYCLES, 0: number of wait states inserted in each access phase (0 = PREADY high on first access cycle).

- PCLK  in  1  sole clock; all state updates on the rising edge.
- PRESET  in  1  reset, synchronous and active-high.
- PSEL  in  1  slave select.
- PENABLE  in  1  access-phase flag.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  AWIDTH  register address.
- PWDATA  in  DWIDTH  write data.
- PRDATA  out  DWIDTH  read data.
- PREADY  out  1  transfer-complete flag.
- PSLVERR  out  1  error response.
- regr_in_0..regr_in_2  in  DWIDTH each  read-only status inputs.
- regw_out_0..regw_out_4  out  DWIDTH each  control register outputs.

## Operation
- Address map:
  - 0–4: regw_out_0..4, read/write.
  - 5–7: regr_in_0..2, read-only.
  - 8–15: unmapped.
- Write to 0–4 on completion: register takes PWDATA; regw_out updates on the completing edge.
- Read of 0–4 returns the register value. Read of 5–7 returns the live regr_in value.
- Error (PSLVERR=1) on:
  - any access to 8–15;
  - a write to 5–7.
- An errored access changes no register. An errored read drives PRDATA=0.
- PRDATA is 0 whenever the slave is not in a read access phase.
- Reset: all regw_out=0, PRDATA=0, PSLVERR=0, PREADY=0, wait counter=0.

## Timing
- Setup phase: PSEL=1, PENABLE=0. Access phase: PSEL=1, PENABLE=1.
- Transfer completes on the rising edge where PSEL & PENABLE & PREADY.
- PREADY:
  - WAIT_CYCLES=0: combinationally high throughout the access phase.
  - Otherwise: high after WAIT_CYCLES access-phase cycles. The counter increments each access cycle with PREADY=0 and clears on completion or PSEL=0.
- PRDATA and PSLVERR are combinational from PADDR/PWRITE. They are valid when PREADY=1 in the access phase; PSLVERR is 0 at all other times.
- Write latency: regw_out shows new data one cycle after the setup phase edge plus WAIT_CYCLES, i.e. the cycle after completion.
- Back-to-back transfers (new setup phase immediately after completion) are supported with no idle cycle.
- PRESET asserted mid-transfer: registers clear on that edge, the in-progress write is discarded and the counter clears. PREADY/PSLVERR/PRDATA are 0 while PRESET=1.
- PENABLE without PSEL is ignored.

## Structure
- Shared package apb_reg_pkg:
  - address constants ADDR_W0..ADDR_W4, ADDR_R0..ADDR_R2;
  - NUM_W=5, NUM_R=3.
- Registers are held internally as an array and fanned out to the regw_out ports.
- One sub-module, apb_wait_ctrl: wait-state counter and PREADY generation. Address decode and the register file stay in the top.

## Test plan
- Reset: hold PRESET 3 cycles, release -> all regw_out=0x00, PREADY=0, PSLVERR=0.
- Write 0xA5 to addr 2, then read addr 2 -> regw_out_2=0xA5 the cycle after completion; PRDATA=0xA5, PSLVERR=0; other regw_out stay 0.
- regr_in_1=0x3C, read addr 6 -> PRDATA=0x3C. Write 0xFF to addr 6 -> PSLVERR=1, PRDATA unaffected, no register changes.
- Read addr 9 -> PSLVERR=1, PRDATA=0x00. Write 0x11 to addr 12 -> PSLVERR=1, all regw_out unchanged.
- WAIT_CYCLES=2, write 0x5A to addr 4 -> PREADY low for 2 access cycles then high; regw_out_4=0x5A only after completion.
- Back-to-back writes 0x01..0x05 to addrs 0..4, then assert PRESET during a further write -> each register holds its value until reset, then all read 0x00.

Source files
------------

// File: rtl/apb_reg_pkg.sv
// Shared constants and address-decode helper for the APB register block.
package apb_reg_pkg;

  localparam int unsigned NUM_W = 5;
  localparam int unsigned NUM_R = 3;

  localparam int unsigned ADDR_W0 = 0;
  localparam int unsigned ADDR_W1 = 1;
  localparam int unsigned ADDR_W2 = 2;
  localparam int unsigned ADDR_W3 = 3;
  localparam int unsigned ADDR_W4 = 4;
  localparam int unsigned ADDR_R0 = 5;
  localparam int unsigned ADDR_R1 = 6;
  localparam int unsigned ADDR_R2 = 7;

  typedef enum logic [1:0] {
    ACC_RW       = 2'd0,
    ACC_RO       = 2'd1,
    ACC_UNMAPPED = 2'd2
  } acc_kind_e;

  // Classifies a word address into read/write, read-only or unmapped space.
  function automatic acc_kind_e decode_addr(input logic [31:0] addr);
    if (addr >= ADDR_W0 && addr <= ADDR_W4) begin
      return ACC_RW;
    end else if (addr >= ADDR_R0 && addr <= ADDR_R2) begin
      return ACC_RO;
    end
    return ACC_UNMAPPED;
  endfunction

endpackage

// File: rtl/apb_reg_if.sv
// APB3 bus bundle between the system master and the register block.
interface apb_reg_if #(
  parameter int unsigned AWIDTH = 4,
  parameter int unsigned DWIDTH = 8
) ();

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [AWIDTH-1:0] PADDR;
  logic [DWIDTH-1:0] PWDATA;
  logic [DWIDTH-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_wait_ctrl.sv
// Wait-state counter: holds PREADY low for WAIT_CYCLES access-phase cycles.
module apb_wait_ctrl #(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic PCLK,
  input  logic PRESET,
  input  logic psel_i,
  input  logic penable_i,
  output logic pready_o
);

  localparam int unsigned CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          access;
  logic          ready;

  assign access   = psel_i & penable_i & ~PRESET;
  assign ready    = (WAIT_CYCLES == 0) || (cnt_q == CW'(WAIT_CYCLES));
  assign pready_o = access & ready;

  // Clears on completion or deselect so every transfer starts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (!psel_i || pready_o) begin
      cnt_d = '0;
    end else if (access) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_reg_top.sv
// APB3 slave with five control registers and three live status inputs.
module apb_reg_top
  import apb_reg_pkg::*;
#(
  parameter int unsigned AWIDTH      = 4,
  parameter int unsigned DWIDTH      = 8,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              PCLK,
  input  logic              PRESET,
  apb_reg_if.slave          apb,
  input  logic [DWIDTH-1:0] regr_in_0,
  input  logic [DWIDTH-1:0] regr_in_1,
  input  logic [DWIDTH-1:0] regr_in_2,
  output logic [DWIDTH-1:0] regw_out_0,
  output logic [DWIDTH-1:0] regw_out_1,
  output logic [DWIDTH-1:0] regw_out_2,
  output logic [DWIDTH-1:0] regw_out_3,
  output logic [DWIDTH-1:0] regw_out_4
);

  logic [DWIDTH-1:0] regs_q    [NUM_W];
  logic [DWIDTH-1:0] regs_d    [NUM_W];
  logic [DWIDTH-1:0] regr_arr  [NUM_R];
  logic [DWIDTH-1:0] rd_data;
  logic [31:0]       addr_int;
  acc_kind_e         kind;
  logic              pready;
  logic              access_phase;
  logic              complete;
  logic              err;

  apb_wait_ctrl #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .psel_i   (apb.PSEL),
    .penable_i(apb.PENABLE),
    .pready_o (pready)
  );

  assign addr_int     = 32'(apb.PADDR);
  assign kind         = decode_addr(addr_int);
  assign access_phase = apb.PSEL & apb.PENABLE & ~PRESET;
  assign complete     = access_phase & pready;
  assign err          = (kind == ACC_UNMAPPED) || ((kind == ACC_RO) && apb.PWRITE);

  assign regr_arr[0] = regr_in_0;
  assign regr_arr[1] = regr_in_1;
  assign regr_arr[2] = regr_in_2;

  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NUM_W; i++) begin
      if (addr_int == ADDR_W0 + i) begin
        rd_data = regs_q[i];
      end
    end
    for (int unsigned i = 0; i < NUM_R; i++) begin
      if (addr_int == ADDR_R0 + i) begin
        rd_data = regr_arr[i];
      end
    end
  end

  // Errored reads return zero; PSLVERR only asserts on the completing cycle.
  assign apb.PRDATA  = (access_phase && !apb.PWRITE && !err) ? rd_data : '0;
  assign apb.PSLVERR = complete & err;
  assign apb.PREADY  = pready;

  always_comb begin
    for (int unsigned i = 0; i < NUM_W; i++) begin
      regs_d[i] = regs_q[i];
      if (complete && apb.PWRITE && !err && (addr_int == ADDR_W0 + i)) begin
        regs_d[i] = apb.PWDATA;
      end
    end
  end

  always_ff @(posedge PCLK) begin
    for (int unsigned i = 0; i < NUM_W; i++) begin
      if (PRESET) begin
        regs_q[i] <= '0;
      end else begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign regw_out_0 = regs_q[0];
  assign regw_out_1 = regs_q[1];
  assign regw_out_2 = regs_q[2];
  assign regw_out_3 = regs_q[3];
  assign regw_out_4 = regs_q[4];

endmodule

// File: tb/tb_apb_reg_top.sv
// Randomized bench for apb_reg_top with zero and two wait states, checked against a register-map model.
module tb_apb_reg_top;
  import apb_reg_pkg::*;

  logic PCLK = 1'b0;
  logic PRESET;
  logic [7:0] rin [3];
  logic [7:0] rw0 [5];
  logic [7:0] rw2 [5];
  logic [7:0] mdl [2][5];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 PCLK = ~PCLK;

  apb_reg_if #(.AWIDTH(4), .DWIDTH(8)) bus0 ();
  apb_reg_if #(.AWIDTH(4), .DWIDTH(8)) bus2 ();

  apb_reg_top #(.AWIDTH(4), .DWIDTH(8), .WAIT_CYCLES(0)) u_dut0 (
    .PCLK(PCLK), .PRESET(PRESET), .apb(bus0),
    .regr_in_0(rin[0]), .regr_in_1(rin[1]), .regr_in_2(rin[2]),
    .regw_out_0(rw0[0]), .regw_out_1(rw0[1]), .regw_out_2(rw0[2]),
    .regw_out_3(rw0[3]), .regw_out_4(rw0[4])
  );

  apb_reg_top #(.AWIDTH(4), .DWIDTH(8), .WAIT_CYCLES(2)) u_dut2 (
    .PCLK(PCLK), .PRESET(PRESET), .apb(bus2),
    .regr_in_0(rin[0]), .regr_in_1(rin[1]), .regr_in_2(rin[2]),
    .regw_out_0(rw2[0]), .regw_out_1(rw2[1]), .regw_out_2(rw2[2]),
    .regw_out_3(rw2[3]), .regw_out_4(rw2[4])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input int which, input logic sel, input logic en, input logic wr,
                       input logic [3:0] a, input logic [7:0] d);
    if (which == 0) begin
      bus0.PSEL = sel; bus0.PENABLE = en; bus0.PWRITE = wr; bus0.PADDR = a; bus0.PWDATA = d;
    end else begin
      bus2.PSEL = sel; bus2.PENABLE = en; bus2.PWRITE = wr; bus2.PADDR = a; bus2.PWDATA = d;
    end
  endtask

  task automatic sample(input int which, output logic rdy, output logic err, output logic [7:0] rd);
    if (which == 0) begin
      rdy = bus0.PREADY; err = bus0.PSLVERR; rd = bus0.PRDATA;
    end else begin
      rdy = bus2.PREADY; err = bus2.PSLVERR; rd = bus2.PRDATA;
    end
  endtask

  function automatic logic [7:0] get_rw(input int which, input int i);
    return (which != 0) ? rw2[i] : rw0[i];
  endfunction

  task automatic check_regs(input int which, input string tag);
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("%s_d%0d_r%0d", tag, which, i), 32'(get_rw(which, i)), 32'(mdl[which][i]));
    end
  endtask

  task automatic clear_model();
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 5; i++) mdl[w][i] = 8'h00;
    end
  endtask

  // Starts #1 after a rising edge and returns #1 after the completing edge.
  task automatic apb_xfer(input int which, input logic wr, input logic [3:0] a, input logic [7:0] d);
    logic rdy, err;
    logic [7:0] rd;
    logic exp_err;
    logic [7:0] exp_rd;
    int waits = 0;
    int wc = (which != 0) ? 2 : 0;
    bit done = 0;
    exp_err = (a >= 4'd8) || (wr && a >= 4'd5);
    if (exp_err || wr)   exp_rd = 8'h00;
    else if (a < 4'd5)   exp_rd = mdl[which][a];
    else                 exp_rd = rin[a - 4'd5];

    drive(which, 1'b1, 1'b0, wr, a, d);
    @(negedge PCLK);
    sample(which, rdy, err, rd);
    check_eq("setup_pready", 32'(rdy), 32'(0));
    check_eq("setup_pslverr", 32'(err), 32'(0));
    check_eq("setup_prdata", 32'(rd), 32'(0));
    @(posedge PCLK); #1;
    drive(which, 1'b1, 1'b1, wr, a, d);
    for (int k = 0; k < 16; k++) begin
      @(negedge PCLK);
      sample(which, rdy, err, rd);
      if (rdy) begin
        done = 1;
        break;
      end
      waits++;
      check_regs(which, "wait_hold");
      @(posedge PCLK); #1;
    end
    check_eq("pready_timeout", 32'(done), 32'(1));
    check_eq("wait_states", 32'(waits), 32'(wc));
    check_eq($sformatf("pslverr_%s_a%0d", wr ? "wr" : "rd", a), 32'(err), 32'(exp_err));
    if (!wr) check_eq($sformatf("prdata_a%0d", a), 32'(rd), 32'(exp_rd));
    @(posedge PCLK); #1;
    drive(which, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    if (wr && !exp_err) mdl[which][a] = d;
    $display("xfer dut%0d %s addr=%0d wdata=0x%02h prdata=0x%02h pslverr=%0d waits=%0d",
             which, wr ? "WR" : "RD", a, d, rd, err, waits);
    check_regs(0, "regs_after");
    check_regs(1, "regs_after");
  endtask

  initial begin
    logic rdy, err;
    logic [7:0] rd;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    rin[0] = 8'h00; rin[1] = 8'h00; rin[2] = 8'h00;
    clear_model();
    PRESET = 1'b1;
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;
    @(negedge PCLK);
    for (int w = 0; w < 2; w++) begin
      sample(w, rdy, err, rd);
      check_eq("reset_pready", 32'(rdy), 32'(0));
      check_eq("reset_pslverr", 32'(err), 32'(0));
      check_regs(w, "reset_regs");
    end
    @(posedge PCLK); #1;

    apb_xfer(0, 1, 4'd2, 8'hA5);
    apb_xfer(0, 0, 4'd2, 8'h00);
    rin[1] = 8'h3C;
    apb_xfer(0, 0, 4'd6, 8'h00);
    apb_xfer(0, 1, 4'd6, 8'hFF);
    apb_xfer(0, 0, 4'd6, 8'h00);
    apb_xfer(0, 0, 4'd9, 8'h00);
    apb_xfer(0, 1, 4'd12, 8'h11);
    apb_xfer(1, 1, 4'd4, 8'h5A);
    apb_xfer(1, 0, 4'd4, 8'h00);

    // PENABLE without PSEL must not start a transfer.
    drive(0, 1'b0, 1'b1, 1'b1, 4'd0, 8'h99);
    @(negedge PCLK);
    sample(0, rdy, err, rd);
    check_eq("penable_only_pready", 32'(rdy), 32'(0));
    @(posedge PCLK); #1;
    drive(0, 0, 0, 0, 0, 0);
    check_regs(0, "penable_only");

    for (int i = 0; i < 5; i++) apb_xfer(0, 1, 4'(i), 8'(i + 1));

    // Reset lands in the access phase of a further write.
    drive(0, 1'b1, 1'b0, 1'b1, 4'd0, 8'h77);
    @(posedge PCLK); #1;
    drive(0, 1'b1, 1'b1, 1'b1, 4'd0, 8'h77);
    PRESET = 1'b1;
    @(negedge PCLK);
    sample(0, rdy, err, rd);
    check_eq("midreset_pready", 32'(rdy), 32'(0));
    check_eq("midreset_pslverr", 32'(err), 32'(0));
    check_eq("midreset_prdata", 32'(rd), 32'(0));
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    clear_model();
    check_regs(0, "midreset_regs");
    check_regs(1, "midreset_regs");
    for (int i = 0; i < 5; i++) apb_xfer(0, 0, 4'(i), 8'h00);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        rin[$urandom_range(0, 2)] = 8'($urandom);
      end
      if ($urandom_range(0, 5) == 0) begin
        @(posedge PCLK); #1;
      end
      apb_xfer(int'($urandom_range(0, 1)), 1'($urandom), 4'($urandom_range(0, 15)), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
